// File: rtl/traffic_sensor_conditioner.sv
// Conditions the raw vehicle-loop detector into the debounced, hold-limited
// car-present request 'x' for the highway/country traffic-light FSM.
module traffic_sensor_conditioner #(
    parameter logic [15:0] TICK_DIV       = 16'd50000,
    parameter logic [7:0]  DEBOUNCE_TICKS = 8'd4,
    parameter logic [7:0]  MIN_HOLD       = 8'd10,
    parameter logic [7:0]  MAX_ASSERT     = 8'd60,
    parameter logic [7:0]  COOLDOWN_TICKS = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       sensor_raw,
    output logic       x,
    output logic       timeout_pulse,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUALIFY  = 2'd1,
        ACTIVE   = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        timeout_q, timeout_d;

    logic s_sync;
    logic tick;
    logic max_hit;

    assign s_sync  = sync2_q;
    assign tick    = (pcnt_q == TICK_DIV - 16'd1);
    assign max_hit = tick && (tcnt_q == MAX_ASSERT - 8'd1);

    // NOTE: every flop updates with <= so all of them sample pre-edge values;
    // reset is synchronous, so it only acts inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pcnt_q    <= '0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pcnt_q    <= pcnt_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_sync) state_d = QUALIFY;
                end
                QUALIFY: begin
                    if (!s_sync)
                        state_d = IDLE;
                    else if (tick && (tcnt_q == DEBOUNCE_TICKS - 8'd1))
                        state_d = ACTIVE;
                end
                ACTIVE: begin
                    // Timeout wins over a release seen on the same cycle.
                    if (max_hit) begin
                        state_d   = COOLDOWN;
                        timeout_d = 1'b1;
                    end else if (!s_sync && (tcnt_q >= MIN_HOLD)) begin
                        state_d = IDLE;
                    end
                end
                COOLDOWN: begin
                    if (tick && (tcnt_q == COOLDOWN_TICKS - 8'd1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sync1_d = sensor_raw;
        sync2_d = sync1_q;
        pcnt_d  = tick ? 16'd0 : pcnt_q + 16'd1;
        tcnt_d  = tcnt_q;
        if ((state_d != state_q) || !en)
            tcnt_d = 8'd0;
        else if (tick && (tcnt_q != 8'hFF))
            tcnt_d = tcnt_q + 8'd1;
    end

    always_comb begin
        x             = (state_q == ACTIVE);
        state_dbg     = state_q;
        timeout_pulse = timeout_q;
    end

endmodule
